// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit slice.
//   tx_state_t : transmitter FSM state encoding (PARITY exists only when the
//                TX_PARITY_EN macro is defined)
//   clog2()    : ceiling log2 constant function used to size pointers, the
//                FIFO level and the data bit counter
// Configuration macro: TX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  // Smallest n with 2**n >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty flags and occupancy count.
// Parameters:
//   WIDTH : word width
//   DEPTH : word count, power of two (pointers wrap naturally modulo DEPTH)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears pointers, level, flags)
//   push  : write din this cycle (ignored while full or in reset)
//   pop   : consume the head word this cycle (ignored while empty or in reset)
//   din   : write data
//   dout  : head word, valid whenever empty = 0
//   full  : registered, level == DEPTH
//   empty : registered, level == 0
//   level : registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic          full_reg, empty_reg;
  logic          push_ok, pop_ok;

  // A push against a full FIFO is dropped even if a pop frees a slot on the
  // same cycle, so acceptance depends only on the registered flag.
  assign push_ok = push && !full_reg && !rst;
  assign pop_ok  = pop && !empty_reg && !rst;

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      full_reg  <= (level_next == FULL_LVL);
      empty_reg <= (level_next == '0);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Head word is read combinationally so the popping cycle can load it
  // straight into the transmitter's shift register.
  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign level = level_reg;

endmodule

// File: rtl/uart_tx_ctl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctl
// Buffered UART transmitter: words pushed into a FIFO are serialised as
// start bit, DATA_W data bits LSB first, optional parity bit, STOP_BITS stop
// bits. Bit timing comes from the external bclk tick; every FSM advance
// happens on a bclk cycle. Frames queue back-to-back with no idle gap.
// Configuration macro: TX_PARITY_EN (adds the PARITY state and parity bit).
// Parameters:
//   DATA_W     : data bits per frame, 5..8
//   FIFO_DEPTH : FIFO words, power of two, 2..256
//   STOP_BITS  : 1 or 2
//   PARITY_ODD : 1 = odd parity, 0 = even (only meaningful with TX_PARITY_EN)
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, aborts any frame in flight
//   bclk     : one-clk baud tick per bit period
//   din      : word to enqueue
//   din_vld  : push request
//   din_rdy  : FIFO not full (from the registered full flag)
//   tx       : serial line, idle high, registered
//   tx_busy  : a frame is on the line (FSM not IDLE)
//   fifo_lvl : FIFO occupancy
//   ovf      : one-cycle pulse on a push dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_ctl
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bclk,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_vld,
  output logic                        din_rdy,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [clog2(FIFO_DEPTH):0]  fifo_lvl,
  output logic                        ovf
);

  localparam int BIT_CW = clog2(DATA_W);
  localparam logic [BIT_CW-1:0] LAST_BIT  = BIT_CW'(DATA_W - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  // An out-of-range parameter set never accepts words, so a misconfigured
  // instance stays silent on the line instead of sending malformed frames.
  localparam bit CFG_OK = (DATA_W >= 5) && (DATA_W <= 8) &&
                          ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                          ((PARITY_ODD == 0) || (PARITY_ODD == 1)) &&
                          (FIFO_DEPTH >= 2) && (FIFO_DEPTH <= 256) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next, shifted;
  logic [BIT_CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic              tx_reg, tx_next;
  logic              pop;

  logic [DATA_W-1:0]          fifo_dout;
  logic                       fifo_full, fifo_empty;
  logic [clog2(FIFO_DEPTH):0] fifo_level;

`ifdef TX_PARITY_EN
  localparam logic PAR_INV = 1'(PARITY_ODD);
  logic parity_reg, parity_next;
`endif

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (din_vld && CFG_OK),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Shift register moved one place toward the LSB, refilled with idle ones.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
    if (gi == DATA_W - 1) begin : g_top
      assign shifted[gi] = 1'b1;
    end else begin : g_mid
      assign shifted[gi] = shift_reg[gi+1];
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    pop           = 1'b0;
`ifdef TX_PARITY_EN
    parity_next   = parity_reg;
`endif

    if (bclk) begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
`ifdef TX_PARITY_EN
            parity_next = (^fifo_dout) ^ PAR_INV;
`endif
            state_next = START;
          end
        end

        START: begin
          state_next = DATA;
        end

        DATA: begin
          shift_next = shifted;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next  = '0;
            stop_cnt_next = 1'b0;
`ifdef TX_PARITY_EN
            state_next    = PARITY;
`else
            state_next    = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end

`ifdef TX_PARITY_EN
        PARITY: begin
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end
`endif

        STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            stop_cnt_next = 1'b0;
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_dout;
`ifdef TX_PARITY_EN
              parity_next = (^fifo_dout) ^ PAR_INV;
`endif
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // The line level is registered and derived from the state being entered,
  // so tx changes exactly one clk after the bclk that caused the advance.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
`ifdef TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
`ifdef TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign din_rdy  = !fifo_full && CFG_OK;
  assign ovf      = din_vld && fifo_full && !rst;
  assign tx       = tx_reg;
  assign tx_busy  = (state_reg != IDLE);
  assign fifo_lvl = fifo_level;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctl
// Self-checking bench for uart_tx_ctl. Several instances cover the default
// build, a shallow FIFO and a 5-bit/2-stop frame (plus odd/even parity
// instances when TX_PARITY_EN is defined). Expected line activity is built
// from the frame format rules as a list of bits, each held one bclk period.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_ctl;

`ifdef TX_PARITY_EN
  localparam int NDUT     = 5;
  localparam int PAR_BITS = 1;
`else
  localparam int NDUT     = 3;
  localparam int PAR_BITS = 0;
`endif

  logic clk;
  logic rst;
  logic bclk;
  logic [NDUT-1:0] din_vld, tx_w, busy_w, rdy_w, ovf_w;
  logic [7:0] din0, din1;
  logic [4:0] din2;
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic [4:0] lvl2;

  int errors;
  int checks;
  int bper;
  int bcnt;
  bit bclk_on;
  logic prev_bclk;

  uart_tx_ctl u0 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din0), .din_vld(din_vld[0]),
    .din_rdy(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_lvl(lvl0), .ovf(ovf_w[0])
  );

  uart_tx_ctl #(.FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din1), .din_vld(din_vld[1]),
    .din_rdy(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_lvl(lvl1), .ovf(ovf_w[1])
  );

  uart_tx_ctl #(.DATA_W(5), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din2), .din_vld(din_vld[2]),
    .din_rdy(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_lvl(lvl2), .ovf(ovf_w[2])
  );

`ifdef TX_PARITY_EN
  logic [7:0] din3, din4;
  logic [4:0] lvl3, lvl4;

  uart_tx_ctl #(.PARITY_ODD(0)) u3 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din3), .din_vld(din_vld[3]),
    .din_rdy(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_lvl(lvl3), .ovf(ovf_w[3])
  );

  uart_tx_ctl #(.PARITY_ODD(1)) u4 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din4), .din_vld(din_vld[4]),
    .din_rdy(rdy_w[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .fifo_lvl(lvl4), .ovf(ovf_w[4])
  );

  function automatic logic parity_of(input logic [7:0] w, input int dw, input int id);
    logic p;
    p = 1'b0;
    for (int b = 0; b < dw; b++) p = p ^ w[b];
    return (id == 4) ? ~p : p;
  endfunction
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
    $fatal(1);
  end

  function automatic int get_lvl(input int id);
    case (id)
      0: return int'(lvl0);
      1: return int'(lvl1);
      2: return int'(lvl2);
`ifdef TX_PARITY_EN
      3: return int'(lvl3);
      4: return int'(lvl4);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic set_din(input int id, input logic [7:0] w);
    case (id)
      0: din0 = w;
      1: din1 = w;
      2: din2 = w[4:0];
`ifdef TX_PARITY_EN
      3: din3 = w;
      4: din4 = w;
`endif
      default: ;
    endcase
  endtask

  // One clock; inputs change 1ns after the edge, bclk generated from bper.
  task automatic tick();
    @(posedge clk);
    #1;
    prev_bclk = bclk;
    if (bclk_on) begin
      if (bcnt >= bper - 1) begin
        bclk = 1'b1;
        bcnt = 0;
      end else begin
        bclk = 1'b0;
        bcnt = bcnt + 1;
      end
    end else begin
      bclk = 1'b0;
    end
  endtask

  task automatic push_words(input int id, input logic [7:0] words[$]);
    foreach (words[i]) begin
      set_din(id, words[i]);
      din_vld[id] = 1'b1;
      tick();
    end
    din_vld[id] = 1'b0;
  endtask

  // Runs bclk with period p and checks the line against the frames expected
  // for the queued words: every bit held p clks, frames contiguous, busy high
  // throughout, level at each frame start equal to the words still waiting.
  task automatic run_frames(input int id, input logic [7:0] words[$], input int dw,
                            input int sb, input int p, input string name);
    logic exp_q[$];
    int   nb, bad, widx;
    bit   found;
    logic last_tx, last_busy;

    nb = 1 + dw + PAR_BITS + sb;
    foreach (words[i]) begin
      exp_q.push_back(1'b0);
      for (int b = 0; b < dw; b++) exp_q.push_back(words[i][b]);
`ifdef TX_PARITY_EN
      exp_q.push_back(parity_of(words[i], dw, id));
`endif
      for (int s = 0; s < sb; s++) exp_q.push_back(1'b1);
    end

    bper = p;
    bcnt = 0;
    bclk_on = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3 * p + 4; k++) begin
      tick();
      if (tx_w[id] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start: tx=%b, required 0 within %0d clk", name, tx_w[id], 3 * p + 4);
      bclk_on = 1'b0;
      bclk = 1'b0;
      return;
    end
    checks++;
    if (prev_bclk !== 1'b1) begin
      errors++;
      $display("FAIL %s start_on_bclk: bclk before start=%b, required 1", name, prev_bclk);
    end

    for (int b = 0; b < exp_q.size(); b++) begin
      bad = 0;
      last_tx = 1'bx;
      last_busy = 1'bx;
      for (int c = 0; c < p; c++) begin
        if (b != 0 || c != 0) tick();
        if (c == 0 && (b % nb) == 0) begin
          widx = b / nb;
          $display("frame %s dut%0d word %0d data=%h lvl=%0d", name, id, widx, words[widx], get_lvl(id));
          checks++;
          if (get_lvl(id) != words.size() - 1 - widx) begin
            errors++;
            $display("FAIL %s lvl frame %0d: fifo_lvl=%0d, required %0d",
                     name, widx, get_lvl(id), words.size() - 1 - widx);
          end
        end
        if (tx_w[id] !== exp_q[b] || busy_w[id] !== 1'b1) begin
          bad++;
          last_tx = tx_w[id];
          last_busy = busy_w[id];
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b busy=%b on %0d of %0d clk, required tx=%b busy=1",
                 name, b, last_tx, last_busy, bad, p, exp_q[b]);
      end
    end

    tick();
    checks++;
    if (tx_w[id] !== 1'b1 || busy_w[id] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: tx=%b busy=%b, required tx=1 busy=0", name, tx_w[id], busy_w[id]);
    end
    bclk_on = 1'b0;
    bclk = 1'b0;
  endtask

  task automatic test_reset();
    // Pushes and ticks during reset must be ignored.
    din_vld = '1;
    for (int i = 0; i < NDUT; i++) set_din(i, 8'h5A);
    bper = 1;
    bcnt = 0;
    bclk_on = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || rdy_w[i] !== 1'b1 ||
          ovf_w[i] !== 1'b0 || get_lvl(i) != 0) begin
        errors++;
        $display("FAIL reset dut%0d: tx=%b busy=%b rdy=%b ovf=%b lvl=%0d, required 1 0 1 0 0",
                 i, tx_w[i], busy_w[i], rdy_w[i], ovf_w[i], get_lvl(i));
      end
    end
    rst = 1'b0;
    din_vld = '0;
    bclk_on = 1'b0;
    bclk = 1'b0;
    tick();
    checks++;
    if (lvl0 !== 5'd0 || tx_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: lvl=%0d tx=%b, required 0 1", lvl0, tx_w[0]);
    end
    $display("reset checked on %0d instances", NDUT);
  endtask

  task automatic test_single_frame();
    logic [7:0] w[$];
    w = '{8'hA5};
    push_words(0, w);
    run_frames(0, w, 8, 1, 16, "single_a5");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[$];
    w = '{8'h01, 8'h02, 8'h03};
    push_words(0, w);
    checks++;
    if (lvl0 !== 5'd3) begin
      errors++;
      $display("FAIL b2b lvl_after_push: fifo_lvl=%0d, required 3", lvl0);
    end
    run_frames(0, w, 8, 1, 16, "b2b");
  endtask

  task automatic test_overflow();
    logic [7:0] w[$];
    logic [7:0] kept[$];
    for (int k = 0; k < 5; k++) w.push_back(8'($urandom));
    for (int k = 0; k < 5; k++) begin
      set_din(1, w[k]);
      din_vld[1] = 1'b1;
      #1;
      checks++;
      if (rdy_w[1] !== (k < 4) || ovf_w[1] !== (k == 4)) begin
        errors++;
        $display("FAIL ovf push %0d: din_rdy=%b ovf=%b, required %b %b",
                 k, rdy_w[1], ovf_w[1], (k < 4), (k == 4));
      end
      $display("push dut1 #%0d data=%h rdy=%b ovf=%b", k, w[k], rdy_w[1], ovf_w[1]);
      tick();
      if (k < 4) kept.push_back(w[k]);
    end
    din_vld[1] = 1'b0;
    #1;
    checks++;
    if (ovf_w[1] !== 1'b0 || rdy_w[1] !== 1'b0 || lvl1 !== 3'd4) begin
      errors++;
      $display("FAIL ovf after: ovf=%b din_rdy=%b lvl=%0d, required 0 0 4", ovf_w[1], rdy_w[1], lvl1);
    end
    run_frames(1, kept, 8, 1, 8, "ovf_drain");
  endtask

  task automatic test_two_stop();
    logic [7:0] w[$];
    w = '{8'h1F};
    push_words(2, w);
    run_frames(2, w, 5, 2, 16, "stop2_1f");
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] w[$];
    w = '{8'h07, 8'($urandom)};
    push_words(3, w);
    run_frames(3, w, 8, 1, 16, "parity_even");
    push_words(4, w);
    run_frames(4, w, 8, 1, 16, "parity_odd");
  endtask
`endif

  task automatic test_random();
    logic [7:0] w[$];
    int id, dw, sb, n, p;
    for (int r = 0; r < 6; r++) begin
      id = (r % 2 == 0) ? 0 : 2;
      dw = (id == 0) ? 8 : 5;
      sb = (id == 0) ? 1 : 2;
      n  = $urandom_range(1, 4);
      p  = $urandom_range(2, 10);
      w.delete();
      for (int k = 0; k < n; k++) w.push_back(8'($urandom) & 8'((1 << dw) - 1));
      push_words(id, w);
      run_frames(id, w, dw, sb, p, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w[$];
    bit found;
    int bad;
    w = '{8'($urandom), 8'($urandom), 8'($urandom)};
    push_words(0, w);
    bper = 16;
    bcnt = 0;
    bclk_on = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx_w[0] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid start: tx=%b, required 0 within 60 clk", tx_w[0]);
    end
    // Start bit, data bits 0 and 1, then partway into data bit 2.
    repeat (16 + 32 + 5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tx_w[0] !== 1'b1 || lvl0 !== 5'd0 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid abort: tx=%b lvl=%0d busy=%b, required 1 0 0", tx_w[0], lvl0, busy_w[0]);
    end
    $display("reset mid-frame dut0 lvl=%0d tx=%b", lvl0, tx_w[0]);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 3 * 10 * 16; k++) begin
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid quiet: line active on %0d clk after reset, required 0", bad);
    end
    bclk_on = 1'b0;
    bclk = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bclk = 1'b0;
    bclk_on = 1'b0;
    prev_bclk = 1'b0;
    bper = 16;
    bcnt = 0;
    din_vld = '0;
    for (int i = 0; i < NDUT; i++) set_din(i, 8'h00);

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_two_stop();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctl.md
UART_TX_CTL -- requirements
Module: uart_tx_ctl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data bits per frame (legal 5..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the FIFO word count (power of two, 2..256).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 selects odd parity and 0 selects even (used only with TX_PARITY_EN).
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-006 SHALL have port clk, input, 1 bit, the sole clock, with all state updating on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port bclk, input, 1 bit, a baud tick: a one-clk-wide pulse once per bit period.
REQ-009 SHALL have port din, input, DATA_W bits, the word to enqueue.
REQ-010 SHALL have port din_vld, input, 1 bit, a push request.
REQ-011 SHALL have port din_rdy, output, 1 bit, which is 1 when the FIFO is not full.
REQ-012 SHALL have port tx, output, 1 bit, the serial line (idle high).
REQ-013 SHALL have port tx_busy, output, 1 bit, which is 1 while a frame is on the line.
REQ-014 SHALL have port fifo_lvl, output, clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.
REQ-015 SHALL have port ovf, output, 1 bit, a one-cycle pulse when a push is dropped.

Function
REQ-016 SHALL enqueue din on any cycle where din_vld=1 and din_rdy=1; din_rdy SHALL be combinational from the registered full flag.
REQ-017 SHALL, when din_vld=1 while the FIFO is full, drop the word, leave the FIFO unchanged and pulse ovf for exactly that cycle, including when a pop occurs on the same cycle.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; every state advance SHALL occur only on a cycle with bclk=1.
REQ-019 SHALL, in IDLE with bclk=1 and fifo_lvl>0, pop one word into the shift register and enter START; tx SHALL go low on the next clk.
REQ-020 SHALL, when a push reaches an empty FIFO on the same cycle as an IDLE bclk, not pop it; the word SHALL start on the next bclk.
REQ-021 SHALL have START last one bit period, then go to DATA.
REQ-022 SHALL have DATA shift out DATA_W bits LSB first, one per bclk, with an internal bit counter wrapping to 0 on exit.
REQ-023 SHALL have DATA go to PARITY when TX_PARITY_EN is defined, and to STOP otherwise.
REQ-024 SHALL have STOP drive tx=1 for STOP_BITS bit periods.
REQ-025 SHALL, on the final STOP bclk, go to START (popping a word on that same cycle) if fifo_lvl>0, else go to IDLE, giving back-to-back frames with no idle gap.
REQ-026 SHALL hold tx_busy=1 in every state except IDLE.
REQ-027 SHALL update fifo_lvl one clk after a push or pop; a simultaneous push and pop on a non-full FIFO SHALL leave fifo_lvl unchanged.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, with rst=1 at a clk edge, set state=IDLE, tx=1, tx_busy=0, fifo_lvl=0, din_rdy=1 and ovf=0, and clear both pointers and the bit counter.
REQ-030 SHALL, on reset mid-frame, abort the frame: tx goes to 1 on the next clk and all queued words are discarded.
REQ-031 SHALL ignore din_vld and bclk while rst=1.

Configuration
REQ-032 SHALL compile in a PARITY state and parity bit when macro TX_PARITY_EN is defined: the bit is the XOR of the data bits, inverted when PARITY_ODD=1, and lasts one bit period.
REQ-033 SHALL, without TX_PARITY_EN, contain no parity logic; the frame is then 1+DATA_W+STOP_BITS bits.

Structure
REQ-034 SHALL place the FSM state encoding and the clog2 helper constant function in shared package uart_pkg.
REQ-035 SHALL implement the FIFO as sub-module sync_fifo (parameters width and depth; ports for push, pop, full, empty and level).

Verification
REQ-036 SHALL verify a single frame: DATA_W=8, no parity, push 0xA5, bclk every 16 clk -> tx bits 0,1,0,1,0,0,1,0,1,1 each lasting 16 clk, with tx_busy high throughout.
REQ-037 SHALL verify back-to-back frames: push 0x01, 0x02 and 0x03 in three consecutive clks -> three frames with no idle bit between them and fifo_lvl stepping 3,2,1,0.
REQ-038 SHALL verify overflow: FIFO_DEPTH=4, bclk held at 0, push 5 words -> din_rdy=0 after the 4th push, ovf pulses once on the 5th, and fifo_lvl=4.
REQ-039 SHALL verify parity: with TX_PARITY_EN, PARITY_ODD=0 and data 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
REQ-040 SHALL verify two stop bits: STOP_BITS=2, DATA_W=5, push 0x1F -> frame 0,1,1,1,1,1,1,1 and 8 bit periods.
REQ-041 SHALL verify reset mid-frame: rst asserted during the 3rd data bit with 2 words queued -> tx=1 and fifo_lvl=0 next clk, and no further frames are sent.
